// File: rtl/multdiv_sequencer.sv
// multdiv_sequencer: issue/completion controller for the iterative multdiv unit.
// Accepts one MULT/DIV request at a time, holds its operands, pulses the matching start
// line for one cycle, waits for resultRDY (or times out) and presents the outcome on a
// valid/ready writeback port. Exposes busy/busy_tag for hazard stalls; flush kills the op.
//
// Ports:
//   clock, reset_n                    clock (rising edge), async active-low reset
//   req_valid/req_ready               request handshake
//   req_is_div, req_a, req_b, req_tag request payload (1=DIV, 0=MULT)
//   flush                             kill in-flight op, drop any captured result
//   mdu_operandA/B                    held operands to the multdiv unit
//   mdu_ctrl_MULT/DIV                 one-cycle start pulses
//   mdu_result/exception/resultRDY    multdiv completion inputs
//   wb_valid/wb_ready                 writeback handshake
//   wb_result, wb_exception, wb_tag   writeback payload
//   busy, busy_tag                    op in START or WAIT, and its tag
module multdiv_sequencer #(
  parameter int unsigned TAG_W       = 5,
  parameter int unsigned TIMEOUT_CYC = 40
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic             req_is_div,
  input  logic [31:0]      req_a,
  input  logic [31:0]      req_b,
  input  logic [TAG_W-1:0] req_tag,
  input  logic             flush,
  output logic [31:0]      mdu_operandA,
  output logic [31:0]      mdu_operandB,
  output logic             mdu_ctrl_MULT,
  output logic             mdu_ctrl_DIV,
  input  logic [31:0]      mdu_result,
  input  logic             mdu_exception,
  input  logic             mdu_resultRDY,
  output logic             wb_valid,
  input  logic             wb_ready,
  output logic [31:0]      wb_result,
  output logic             wb_exception,
  output logic [TAG_W-1:0] wb_tag,
  output logic             busy,
  output logic [TAG_W-1:0] busy_tag
);

  localparam int unsigned CntW = $clog2(TIMEOUT_CYC + 1);

  typedef enum logic [1:0] {StIdle, StStart, StWait, StDone} state_e;

  state_e            state_q, state_d;
  logic [31:0]       a_q, a_d;
  logic [31:0]       b_q, b_d;
  logic              is_div_q, is_div_d;
  logic [TAG_W-1:0]  tag_q, tag_d;
  logic [31:0]       res_q, res_d;
  logic              exc_q, exc_d;
  logic [CntW-1:0]   cnt_q, cnt_d;
  logic              accept;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= StIdle;
      a_q      <= '0;
      b_q      <= '0;
      is_div_q <= 1'b0;
      tag_q    <= '0;
      res_q    <= '0;
      exc_q    <= 1'b0;
      cnt_q    <= '0;
    end else begin
      state_q  <= state_d;
      a_q      <= a_d;
      b_q      <= b_d;
      is_div_q <= is_div_d;
      tag_q    <= tag_d;
      res_q    <= res_d;
      exc_q    <= exc_d;
      cnt_q    <= cnt_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    a_d      = a_q;
    b_d      = b_q;
    is_div_d = is_div_q;
    tag_d    = tag_q;
    res_d    = res_q;
    exc_d    = exc_q;
    cnt_d    = cnt_q;

    // reset_n gating keeps req_ready low while reset is asserted even though state is IDLE.
    req_ready = reset_n && !flush &&
                ((state_q == StIdle) || ((state_q == StDone) && wb_ready));
    accept    = req_valid && req_ready;

    unique case (state_q)
      StIdle: ;
      StStart: begin
        // resultRDY deliberately ignored here: it may be stale from a flushed op.
        cnt_d   = '0;
        state_d = StWait;
      end
      StWait: begin
        if (mdu_resultRDY) begin
          res_d   = mdu_result;
          exc_d   = mdu_exception;
          state_d = StDone;
        end else if (cnt_q == CntW'(TIMEOUT_CYC - 1)) begin
          res_d   = '0;
          exc_d   = 1'b1;
          state_d = StDone;
        end else begin
          cnt_d = cnt_q + CntW'(1);
        end
      end
      StDone: begin
        if (wb_ready) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase

    if (accept) begin
      a_d      = req_a;
      b_d      = req_b;
      is_div_d = req_is_div;
      tag_d    = req_tag;
      state_d  = StStart;
    end

    if (flush) state_d = StIdle;
  end

  assign mdu_operandA  = a_q;
  assign mdu_operandB  = b_q;
  assign mdu_ctrl_MULT = (state_q == StStart) && !is_div_q;
  assign mdu_ctrl_DIV  = (state_q == StStart) && is_div_q;
  assign wb_valid      = (state_q == StDone);
  assign wb_result     = res_q;
  assign wb_exception  = exc_q;
  assign wb_tag        = tag_q;
  assign busy          = (state_q == StStart) || (state_q == StWait);
  assign busy_tag      = tag_q;

endmodule
